// File: rtl/bus_arbiter.sv
// bus_arbiter: 68000 BR/BG/BGACK bus arbiter with round-robin one-hot grants and bounded tenure chaining.
// Optional feature: define ARB_TIMEOUT_EN to revoke tenures that last HOLD_MAX cycles and mask the
// revoked requester until it drops its request; undefined, tenures are unbounded and TIMEOUT is 0.
module bus_arbiter #(
    parameter int NREQ      = 2,
    parameter int MAX_CHAIN = 4,
    parameter int HOLD_MAX  = 64
) (
    input  logic            CPUCLK_IN,
    input  logic            RESET_IN,
    input  logic [NREQ-1:0] REQ_IN,
    input  logic            BG_IN,
    input  logic            AS_IN,
    input  logic            DTACK_IN,
    output logic            BR,
    output logic            BGACK,
    output logic [NREQ-1:0] GNT,
    output logic            BUSY,
    output logic            TIMEOUT
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_CHAIN + 1);

    if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
        $error("bus_arbiter: NREQ must be 1..8");
    end
    if (MAX_CHAIN < 1) begin : g_bad_chain
        $error("bus_arbiter: MAX_CHAIN must be >= 1");
    end
    if (HOLD_MAX < 1) begin : g_bad_hold
        $error("bus_arbiter: HOLD_MAX must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, REQUEST, OWN, HANDOFF, RELEASE} state_t;

    state_t          state, next_state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [NREQ-1:0] win_oh;
    logic [NREQ-1:0] owner_oh;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] others;
    logic [CW-1:0]   chain_cnt;
    logic            timeout_hit;
    logic            owner_done;
    logic            bus_free;
    logic            enter_own;
    logic            br_d, bgack_d, busy_d;
    logic [NREQ-1:0] gnt_d;

    // First eligible index strictly after p, wrapping; p itself is checked last.
    function automatic logic [PW-1:0] next_winner(input logic [NREQ-1:0] e, input logic [PW-1:0] p);
        int idx;
        next_winner = p;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(p) + i) % NREQ;
            if (e[idx]) next_winner = PW'(idx);
        end
    endfunction

    assign elig      = REQ_IN & ~mask;
    assign win       = next_winner(elig, ptr);
    assign win_oh    = NREQ'(1) << win;
    assign owner_oh  = NREQ'(1) << ptr;
    assign others    = elig & ~owner_oh;
    assign bus_free  = BG_IN && !AS_IN && !DTACK_IN;
    assign owner_done = !REQ_IN[ptr] || timeout_hit;
    assign enter_own = next_state == OWN && state != OWN;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    logic [TW-1:0] tenure;

    assign timeout_hit = state == OWN && tenure == TW'(HOLD_MAX - 1) && REQ_IN[ptr];

    // Tenure counter, revoke mask (held until the requester lets go) and the one-cycle TIMEOUT pulse.
    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            tenure  <= '0;
            mask    <= '0;
            TIMEOUT <= 1'b0;
        end else begin
            tenure  <= (state == OWN) ? tenure + 1'b1 : '0;
            mask    <= (mask | (timeout_hit ? owner_oh : '0)) & REQ_IN;
            TIMEOUT <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mask        = '0;
    assign TIMEOUT     = 1'b0;
`endif

    // State, pointer, chain count and registered outputs.
    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            state     <= IDLE;
            ptr       <= PW'(NREQ - 1);
            chain_cnt <= '0;
            BR        <= 1'b0;
            BGACK     <= 1'b0;
            GNT       <= '0;
            BUSY      <= 1'b0;
        end else begin
            state <= next_state;
            BR    <= br_d;
            BGACK <= bgack_d;
            GNT   <= gnt_d;
            BUSY  <= busy_d;
            if (enter_own) begin
                ptr       <= win;
                chain_cnt <= (chain_cnt == CW'(MAX_CHAIN)) ? chain_cnt : chain_cnt + 1'b1;
            end else if (state == RELEASE) begin
                chain_cnt <= '0;
            end
        end
    end

    // Next state; leaving OWN is the end-of-tenure decision between handoff and release.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = |elig ? REQUEST : IDLE;
            REQUEST: next_state = !(|elig) ? IDLE : bus_free ? OWN : REQUEST;
            OWN:     next_state = !owner_done ? OWN :
                                  (|others && chain_cnt < CW'(MAX_CHAIN)) ? HANDOFF : RELEASE;
            HANDOFF: next_state = |elig ? OWN : RELEASE;
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs for the state being entered, so they appear registered right after the transition edge.
    always_comb begin
        br_d    = next_state == REQUEST;
        bgack_d = next_state == OWN || next_state == HANDOFF;
        busy_d  = next_state == OWN;
        gnt_d   = (next_state != OWN) ? '0 : (state == OWN) ? GNT : win_oh;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Arbitrates the 68000 bus between NREQ auxiliary masters (DMA, monitor, debug injector) and the CPU. It runs the 68000 BR/BG/BGACK handshake and grants the bus one-hot to requesters in round-robin order. It can chain tenures back-to-back without returning the bus to the CPU, up to a bounded number of tenures. It sits beside BusControl on CPUCLK; the top level inverts its active-high outputs onto BR_n/BGACK_n.

## Interface
- NREQ, 2: number of requesters (1..8).
- MAX_CHAIN, 4: maximum consecutive tenures before the bus must be returned to the CPU.
- HOLD_MAX, 64: maximum cycles per tenure. Only used with ARB_TIMEOUT_EN.

- CPUCLK_IN  in  1  CPU clock; all logic runs on its rising edge.
- RESET_IN  in  1  reset, synchronous, active-high.
- REQ_IN  in  NREQ  per-requester bus request, level. A requester holds it until it is done.
- BG_IN  in  1  CPU bus grant, active-high.
- AS_IN  in  1  address strobe, active-high.
- DTACK_IN  in  1  DTACK, active-high.
- BR  out  1  bus request to the CPU.
- BGACK  out  1  bus grant acknowledge to the CPU.
- GNT  out  NREQ  one-hot grant; at most one bit is set.
- BUSY  out  1  an auxiliary master owns the bus; BusControl steers chip-selects from this.
- TIMEOUT  out  1  one-cycle pulse when a tenure is revoked.

## Operation
- All outputs are registered.
- Reset values: BR=0, BGACK=0, GNT=0, BUSY=0, TIMEOUT=0, state IDLE, chain count 0, round-robin pointer NREQ-1 (requester 0 wins first).
- Eligible requesters: `REQ_IN & ~mask`. A requester's mask bit is set when it is revoked and clears on the first cycle its REQ_IN is low.
- States:
  - IDLE: BR=0, BGACK=0. Any eligible REQ → REQUEST.
  - REQUEST: BR=1.
    - No eligible REQ → IDLE. BR drops and the CPU resumes.
    - BG_IN=1 and AS_IN=0 and DTACK_IN=0 (same cycle) → OWN.
    - Otherwise stay.
  - OWN: BGACK=1, BR=0, BUSY=1, GNT=onehot(winner).
    - Winner: first eligible index strictly after the pointer, wrapping modulo NREQ.
    - The winner is chosen on the cycle OWN is entered; the pointer is updated to the winner and the chain count is incremented.
    - Owner's REQ_IN low (or revoked) → END.
  - END (decision in the same cycle the owner drops):
    - Another eligible REQ and chain count < MAX_CHAIN → HANDOFF.
    - Otherwise → RELEASE.
  - HANDOFF: 1 cycle, GNT=0, BGACK=1, BUSY=0. Then → OWN with the next winner.
  - RELEASE: 1 cycle, GNT=0, BGACK=0, BR=0, chain count cleared. Then → IDLE.
- Simultaneous events:
  - Owner drops while new requests arrive: the new requests are considered in the END decision.
  - BG_IN and all REQ_IN falling in the same REQUEST cycle: the dropping requests win → IDLE.
- Reset mid-tenure: all outputs return to their reset values on the next edge, including BGACK=0 and GNT=0.
- GNT and BGACK are never high while the state is REQUEST.
- The chain count saturates at MAX_CHAIN.

## Timing
- REQ_IN rises at edge n (IDLE) → BR=1 after edge n+1.
- Bus-free condition sampled at edge m → BGACK=1, GNT valid, BR=0 after edge m+1.
- Owner REQ_IN low at edge k → GNT=0 after edge k+1. Next grant (handoff) after edge k+2.
- Owner REQ_IN low at edge k → BGACK=0 (release) after edge k+1; BR may reassert after edge k+3 at the earliest.
- Minimum bus-return window to the CPU: 2 cycles (RELEASE + IDLE).
- GNT changes only on state transitions; no glitch-level changes.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A tenure counter clears on OWN entry and increments each OWN cycle.
  - At count HOLD_MAX-1 with the owner's REQ_IN still high: TIMEOUT=1 for one cycle, GNT drops, the owner is masked, and END rules apply.
- ARB_TIMEOUT_EN undefined:
  - No counter.
  - TIMEOUT is constant 0 and the mask is always 0.
  - HOLD_MAX is ignored; tenures are unbounded.

## Test plan
- Single requester, NREQ=2: REQ_IN=01, BG_IN raised 3 cycles after BR → BGACK=1, GNT=01. Drop REQ → GNT=00 next edge, BGACK=0, state IDLE after 2 cycles.
- Round robin: REQ_IN=11 held, each owner drops after 5 cycles then re-requests → grant order 0,1,0,1. After 4 tenures (MAX_CHAIN=4) BGACK drops for ≥2 cycles before BR reasserts.
- Bus busy: BG_IN=1 with AS_IN=1 for 4 cycles, then AS_IN=0 and DTACK_IN=0 → BGACK asserts exactly 1 cycle after the free sample, never earlier.
- Abandoned request: REQ_IN 01→00 while in REQUEST with BG_IN=0 → BR=0 next edge. No GNT, no BGACK.
- Reset mid-tenure: RESET_IN=1 during OWN → BR, BGACK, GNT, BUSY all 0 after that edge; first grant after reset goes to requester 0.
- With ARB_TIMEOUT_EN, HOLD_MAX=8: owner holds REQ → TIMEOUT pulse at the 8th OWN cycle, GNT revoked. The requester gets no grant until it drops REQ_IN for ≥1 cycle.
